// File: rtl/proj_fm_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// proj_fm_sweep_ctrl
//
// Sequencer for the Flajolet-Martin sketch buffer RAM. A job runs three
// phases over the buffer:
//   clear   - writes zero to every entry, one entry per cycle
//   collect - ORs incoming hash-derived bit vectors into entries with a
//             read-modify-write (one update every two cycles at most)
//   drain   - streams every entry out in index order over valid/ready
//
// Ports
//   in_clk, in_rst_n       clock (rising edge), async active-low reset
//   in_start               pulse, begins a job (honoured only when idle)
//   in_upd_valid/idx/bits  update request: OR bits into entry idx
//   out_upd_ready          update accepted when valid && ready
//   in_flush               pulse, ends collect and starts drain
//   ram_addr/wr_en/wr_data RAM address and write port
//   ram_rd_en/rd_data      RAM read port, data arrives the cycle after rd_en
//   out_valid/data/idx     drained entry stream (data/idx registered)
//   in_out_ready           downstream ready
//   out_busy               high whenever a job is in progress
//   out_done               one-cycle pulse at job end
// ---------------------------------------------------------------------------
module proj_fm_sweep_ctrl #(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int DATA_W = 32
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic              in_start,
  input  logic              in_upd_valid,
  input  logic [IDX_W-1:0]  in_upd_idx,
  input  logic [DATA_W-1:0] in_upd_bits,
  output logic              out_upd_ready,
  input  logic              in_flush,
  output logic [IDX_W-1:0]  ram_addr,
  output logic              ram_wr_en,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              ram_rd_en,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  input  logic              in_out_ready,
  output logic              out_busy,
  output logic              out_done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_COLLECT,
    ST_UPD_WR,
    ST_DRAIN_RD,
    ST_DRAIN_CAP,
    ST_DRAIN_OUT,
    ST_DONE
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;            // clear / update / drain index
  logic [DATA_W-1:0]   bits_q, bits_d;          // latched update bits
  logic                flush_pending_q, flush_pending_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [IDX_W-1:0]    out_idx_q, out_idx_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge value, independent of block ordering. The RAM itself lives
  // outside this block and is deliberately left untouched by reset.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q         <= ST_IDLE;
      idx_q           <= '0;
      bits_q          <= '0;
      flush_pending_q <= 1'b0;
      out_data_q      <= '0;
      out_idx_q       <= '0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      bits_q          <= bits_d;
      flush_pending_q <= flush_pending_d;
      out_data_q      <= out_data_d;
      out_idx_q       <= out_idx_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    bits_d          = bits_q;
    flush_pending_d = flush_pending_q;
    out_data_d      = out_data_q;
    out_idx_d       = out_idx_q;
    ram_addr        = '0;
    ram_wr_en       = 1'b0;
    ram_wr_data     = '0;
    ram_rd_en       = 1'b0;
    out_upd_ready   = 1'b0;
    out_valid       = 1'b0;
    out_done        = 1'b0;

    // A flush arriving before the drain is remembered until collect can
    // service it; in idle and during drain it has no meaning.
    if (in_flush && (state_q inside {ST_CLEAR, ST_COLLECT, ST_UPD_WR})) begin
      flush_pending_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (in_start) begin
          idx_d   = '0;
          state_d = ST_CLEAR;
        end
      end

      ST_CLEAR: begin
        ram_wr_en = 1'b1;
        ram_addr  = idx_q;
        idx_d     = idx_q + IDX_ONE;  // wraps to 0 after the last entry
        if (idx_q == LAST_IDX) begin
          state_d = ST_COLLECT;
        end
      end

      ST_COLLECT: begin
        out_upd_ready = 1'b1;
        // An accepted update takes priority; a pending flush waits for the
        // write-back so the drain sees the merged value.
        if (in_upd_valid) begin
          ram_rd_en = 1'b1;
          ram_addr  = in_upd_idx;
          idx_d     = in_upd_idx;
          bits_d    = in_upd_bits;
          state_d   = ST_UPD_WR;
        end else if (flush_pending_q) begin
          flush_pending_d = 1'b0;
          idx_d           = '0;
          state_d         = ST_DRAIN_RD;
        end
      end

      ST_UPD_WR: begin
        // The write lands before the next read can be issued, so repeated
        // updates to one entry always merge against the latest value.
        ram_wr_en   = 1'b1;
        ram_addr    = idx_q;
        ram_wr_data = ram_rd_data | bits_q;
        state_d     = ST_COLLECT;
      end

      ST_DRAIN_RD: begin
        ram_rd_en = 1'b1;
        ram_addr  = idx_q;
        state_d   = ST_DRAIN_CAP;
      end

      ST_DRAIN_CAP: begin
        out_data_d = ram_rd_data;
        out_idx_d  = idx_q;
        state_d    = ST_DRAIN_OUT;
      end

      ST_DRAIN_OUT: begin
        out_valid = 1'b1;
        if (in_out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + IDX_ONE;
            state_d = ST_DRAIN_RD;
          end
        end
      end

      ST_DONE: begin
        out_done = 1'b1;
        state_d  = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign out_data = out_data_q;
  assign out_idx  = out_idx_q;
  assign out_busy = (state_q != ST_IDLE);

endmodule

// File: doc/proj_fm_sweep_ctrl.md
Name: proj_fm_sweep_ctrl

Overview:
- Sequencer for the Flajolet-Martin (FM) sketch buffer RAM. Each job runs three phases on the buffer: clear, collect, drain.
- Clear writes zero to every entry.
- Collect merges incoming hash-derived bit vectors into entries with an OR read-modify-write.
- Drain streams every entry out in index order over a valid/ready interface.
- Sits between the hash/update pipeline, the FM buffer RAM (1-cycle read latency) and the downstream estimator.

Parameters:
- DEPTH, 16, number of FM buffer entries. Must be a power of two and at least 2.
- IDX_W, $clog2(DEPTH), width of the entry index.
- DATA_W, 32, width of one FM bitmap entry.

Ports:
- in_clk  input  1  clock; all logic on rising edge.
- in_rst_n  input  1  asynchronous active-low reset.
- in_start  input  1  pulse; begins a job. Honoured only in IDLE.
- in_upd_valid  input  1  update request valid.
- in_upd_idx  input  IDX_W  entry to update.
- in_upd_bits  input  DATA_W  bits to OR into the entry.
- out_upd_ready  output  1  update accepted when valid&&ready.
- in_flush  input  1  pulse; end collect and start drain.
- ram_addr  output  IDX_W  RAM address.
- ram_wr_en  output  1  RAM write strobe.
- ram_wr_data  output  DATA_W  RAM write data.
- ram_rd_en  output  1  RAM read strobe. Data is valid on ram_rd_data the next cycle.
- ram_rd_data  input  DATA_W  RAM read data.
- out_valid  output  1  drained entry valid.
- out_data  output  DATA_W  drained entry value (registered).
- out_idx  output  IDX_W  index of the drained entry.
- in_out_ready  input  1  downstream ready.
- out_busy  output  1  high whenever state != IDLE.
- out_done  output  1  one-cycle pulse at job end.

Behaviour:
- Reset: async on in_rst_n low.
  - State goes to IDLE, idx=0 and flush_pending=0.
  - All outputs are 0, including ram_* strobes, out_valid and out_done.
  - Reset mid-job abandons the job. RAM contents are not touched.
- IDLE:
  - in_start moves to CLEAR with idx=0.
  - in_upd_valid and in_flush are ignored; out_upd_ready=0.
- CLEAR: each cycle drives ram_wr_en=1, ram_addr=idx, ram_wr_data=0, then idx++.
  - After the write at idx=DEPTH-1: idx wraps to 0, go to COLLECT.
  - Exactly DEPTH cycles.
- COLLECT: out_upd_ready=1.
  - On valid&&ready: drive ram_rd_en=1 with ram_addr=in_upd_idx, latch idx/bits, go to UPD_WR.
  - Else if flush_pending: clear it, set idx=0, go to DRAIN_RD.
  - An update accepted in the same cycle as a flush wins; the flush is serviced afterwards.
- UPD_WR: out_upd_ready=0. Drive ram_wr_en=1, ram_addr=latched idx, ram_wr_data=ram_rd_data|latched bits. Return to COLLECT.
  - Result: max update throughput is 1 per 2 cycles.
  - Back-to-back updates to the same index are correct because each write completes before the next read.
- flush_pending:
  - Set by in_flush in CLEAR, COLLECT or UPD_WR.
  - Ignored in IDLE and drain states.
  - Sticky until serviced.
- DRAIN_RD: ram_rd_en=1, ram_addr=idx, go to DRAIN_CAP.
- DRAIN_CAP: out_data<=ram_rd_data and out_idx<=idx at end of cycle, go to DRAIN_OUT.
- DRAIN_OUT: out_valid=1, with out_data/out_idx held stable until in_out_ready.
  - On handshake: if idx==DEPTH-1 go to DONE, else idx++ and go to DRAIN_RD.
  - out_valid deasserts the cycle after the handshake.
  - Minimum 3 cycles per entry.
- DONE: out_done=1 for one cycle, then IDLE.
- in_start outside IDLE is ignored (no restart).
- idx wraps modulo DEPTH. There are no out-of-range indices because DEPTH is a power of two.
- ram_wr_en and ram_rd_en are never both 1 in the same cycle.

Test Plan:
- Reset, then in_start → out_busy=1 next cycle; 16 writes of 0 at addresses 0..15 on consecutive cycles; out_upd_ready=1 on the 17th cycle after start.
- COLLECT, updates (idx 3, 0x1), (idx 3, 0x4), (idx 15, 0x80000000) back-to-back → ready alternates 1/0; RAM[3]=0x5, RAM[15]=0x80000000.
- in_flush pulse, in_out_ready=1 → 16 beats with out_idx 0..15 in order; beat 3 data=0x5, beat 15=0x80000000, others 0; out_done pulses once after beat 15; then IDLE.
- in_out_ready held 0 for 5 cycles on beat 7 → out_valid stays 1 with data/idx stable; beat 8 follows only after ready.
- in_flush in the same cycle as an accepted update (idx 9, 0x2) → update written first; drain then shows RAM[9]=0x2.
- in_rst_n low during beat 5 of drain → all outputs 0 asynchronously; after release the block stays IDLE until in_start; a new job clears all 16 entries.
